// File: rtl/csa_nibble_seq_if.sv
// Operand/result handshake bundle for csa_nibble_seq.
// The master side drives operands and accepts results; the slave side is the adder.
interface csa_nibble_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/csa_nibble_seq.sv
// Wide add/subtract built from one 4-bit carry-select slice, stepped over NIBBLES
// nibbles (LSB first) with the inter-nibble carry held in a register.
module csa_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input logic              clk,
    input logic              rst,
    csa_nibble_seq_if.slave  bus
);
    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned CW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [CW+1:0]    base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       pre0;
    logic [4:0]       pre1;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             last;

    assign base  = {cnt_q, 2'b00};
    assign nib_a = a_q[base +: 4];
    assign nib_b = b_q[base +: 4];

    // Carry-select slice: both carry outcomes are formed, the carry register picks one.
    assign pre0 = {1'b0, nib_a} + {1'b0, nib_b};
    assign pre1 = {1'b0, nib_a} + {1'b0, nib_b} + 5'd1;
    assign {slice_cout, slice_sum} = carry_q ? pre1 : pre0;

    assign last = (cnt_q == CW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        // Subtraction is a + ~b + 1, so cin is replaced by the +1.
                        carry_q    <= bus.sub | bus.cin;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    sum_q[base +: 4] <= slice_sum;
                    carry_q          <= slice_cout;
                    if (last) begin
                        cout_q      <= slice_cout;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (slice_sum[3] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_csa_nibble_seq.sv
// Scoreboard bench for csa_nibble_seq: expected results come from plain integer arithmetic
// and are popped by an independent monitor at each result handshake.
module tb_csa_nibble_seq;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned WIDTH   = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

    csa_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors     = 0;
    int   checks     = 0;
    int   cycle      = 0;
    int   accept_cyc = 0;
    logic prev_ov    = 1'b0;
    logic rand_rdy   = 1'b0;
    logic force_rdy  = 1'b1;
    logic rnd_bit    = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    assign bus.out_ready = rand_rdy ? rnd_bit : force_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   r;
        longint ua = longint'({48'b0, a});
        longint ub = longint'({48'b0, b});
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint full;
        longint sr;
        if (sub) begin
            full   = ua - ub;
            r.cout = (ua >= ub);
            sr     = sa - sbv;
        end else begin
            full   = ua + ub + longint'(cin);
            r.cout = (full >= 65536);
            sr     = sa + sbv + longint'(cin);
        end
        r.sum = full[WIDTH-1:0];
        r.ovf = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // Monitor: checks control invariants every cycle and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            check("busy_vs_ready", 32'(bus.busy), 32'(!bus.in_ready));
            if (bus.out_valid) begin
                check("ready_low_in_done", 32'(bus.in_ready), 32'd0);
                if (!prev_ov) check("latency", 32'(cycle - accept_cyc), NIBBLES);
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got sum=%h expected none", bus.sum);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sum", 32'(bus.sum), 32'(mon_e.sum));
                        check("cout", 32'(bus.cout), 32'(mon_e.cout));
                        check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
                    end
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // Called and returns aligned to 1 time unit after a rising edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        @(posedge clk);
        #1;
        accept_cyc   = cycle;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
        sb_q.push_back(model(a, b, cin, sub));
        check("ready_low_in_run", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    endtask

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    exp_t             hold_e;

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h000F, 16'h0000, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();

        // Backpressure: result held, new operands refused
        force_rdy = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        hold_e = model(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum", 32'(bus.sum), 32'(hold_e.sum));
            check("bp_cout", 32'(bus.cout), 32'(hold_e.cout));
            check("bp_ovf", 32'(bus.ovf), 32'(hold_e.ovf));
            bus.in_valid = 1'(i % 2 == 0);
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        force_rdy    = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_queue_empty", 32'(sb_q.size()), 32'd0);

        // Reset during RUN after nibble 1 has been written
        bus.in_valid = 1'b1;
        bus.a        = 16'hABCD;
        bus.b        = 16'h1234;
        bus.cin      = 1'b1;
        bus.sub      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();

        // Randomized traffic with random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 1) ra = 16'h7FFF;
            if (i % 8 == 2) rb = 16'hFFFF;
            if (i % 8 == 3) ra = 16'h8000;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
